dc_cache_wb: RTL and testbench

//  Parametrised N-way set-associative L1 data-cache tag/state controller: write-back, write-allocate, true LRU.

---
 rtl/dc_pkg.sv | 31 +++
 rtl/dc_lru_ages.sv | 29 ++
 rtl/dc_cache_wb.sv | 241 ++++++++++++++++++++++++
 tb/tb_dc_cache_wb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared codes and types for the dc_cache_wb write-back L1 data-cache controller.
package dc_pkg;

  localparam logic [3:0] N_READ  = 4'd0;
  localparam logic [3:0] N_WRITE = 4'd1;
  localparam logic [3:0] N_INVAL = 4'd3;
  localparam logic [3:0] N_RESET = 4'd8;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WB    = 2'b10;
  localparam logic [1:0] CMD_RWITM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOOKUP,
    S_EVICT,
    S_FILL
  } state_t;

  function automatic logic is_access(input logic [3:0] code);
    return (code == N_READ) || (code == N_WRITE);
  endfunction

  // A write miss fetches with intent to modify so the line arrives exclusive.
  function automatic logic [1:0] fill_cmd(input logic [3:0] code);
    return (code == N_WRITE) ? CMD_RWITM : CMD_READ;
  endfunction

endpackage

// File: rtl/dc_lru_ages.sv
// True-LRU age update and victim pick for one set; purely combinational.
module dc_lru_ages #(
  parameter int WAYS  = 4,
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] ages_in,
  input  logic [AGE_W-1:0]      touch,
  output logic [WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]      victim
);

  logic [AGE_W-1:0] touched_age;

  // Ages form a permutation of 0..WAYS-1; the oldest way is the one at WAYS-1.
  always_comb begin
    touched_age = ages_in[touch*AGE_W +: AGE_W];
    ages_out    = ages_in;
    victim      = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w == int'(touch))
        ages_out[w*AGE_W +: AGE_W] = '0;
      else if (ages_in[w*AGE_W +: AGE_W] < touched_age)
        ages_out[w*AGE_W +: AGE_W] = ages_in[w*AGE_W +: AGE_W] + AGE_W'(1);
      if (ages_in[w*AGE_W +: AGE_W] == AGE_W'(WAYS-1))
        victim = AGE_W'(w);
    end
  end

endmodule

// File: rtl/dc_cache_wb.sv
// N-way write-back, write-allocate L1 data-cache tag/state controller with true LRU.
// Define DC_STATS_EN to build the hit/miss/reads/writes statistics counters.
module dc_cache_wb
  import dc_pkg::*;
#(
  parameter int WAYS        = 4,
  parameter int SET_BITS    = 14,
  parameter int OFFSET_BITS = 6,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               n,
  input  logic [ADDR_W-1:0]        add_in,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [ADDR_W-OFFSET_BITS-1:0] add_out,
  output logic [1:0]               cmd_out,
  output logic [CNT_W-1:0]         hit,
  output logic [CNT_W-1:0]         miss,
  output logic [CNT_W-1:0]         reads,
  output logic [CNT_W-1:0]         writes
);

  localparam int SETS   = 2**SET_BITS;
  localparam int TAG_W  = ADDR_W - SET_BITS - OFFSET_BITS;
  localparam int LINE_W = ADDR_W - OFFSET_BITS;
  localparam int AGE_W  = $clog2(WAYS);

  function automatic logic [WAYS*AGE_W-1:0] ages_init();
    logic [WAYS*AGE_W-1:0] r;
    for (int w = 0; w < WAYS; w++) r[w*AGE_W +: AGE_W] = AGE_W'(w);
    return r;
  endfunction

  state_t state, nxt;

  logic [3:0]          req_n;
  logic [LINE_W-1:0]   req_line;
  logic [SET_BITS-1:0] set_cnt;
  logic                clr_resp;
  logic [AGE_W-1:0]    vic_way;
  logic [LINE_W-1:0]   bus_addr;
  logic [1:0]          bus_cmd;

  logic [TAG_W-1:0]       tag_arr [SETS][WAYS];
  logic [WAYS-1:0]        valid_arr [SETS];
  logic [WAYS-1:0]        dirty_arr [SETS];
  logic [WAYS*AGE_W-1:0]  age_arr [SETS];

  logic [SET_BITS-1:0] req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                tag_hit, inv_found, vic_dirty, hit_dirty;
  logic [AGE_W-1:0]    hit_way, inv_way, lru_victim, miss_way, evict_way, lru_touch;
  logic [WAYS*AGE_W-1:0] ages_next;

  logic unused_offset;
  assign unused_offset = ^add_in[OFFSET_BITS-1:0];

  assign req_idx = req_line[SET_BITS-1:0];
  assign req_tag = req_line[LINE_W-1 -: TAG_W];

  // Tag compare across all ways; descending scan makes the lowest index win.
  always_comb begin
    tag_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
        tag_hit = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_arr[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
    end
  end

  assign miss_way  = inv_found ? inv_way : lru_victim;
  assign evict_way = is_access(req_n) ? miss_way : hit_way;
  assign vic_dirty = valid_arr[req_idx][miss_way] && dirty_arr[req_idx][miss_way];
  assign hit_dirty = dirty_arr[req_idx][hit_way];
  assign lru_touch = (state == S_LOOKUP) ? hit_way : vic_way;

  dc_lru_ages #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .ages_in  (age_arr[req_idx]),
    .touch    (lru_touch),
    .ages_out (ages_next),
    .victim   (lru_victim)
  );

  assign req_ready = (state == S_IDLE);
  assign bus_valid = (state == S_EVICT) || (state == S_FILL);
  assign cmd_out   = bus_valid ? bus_cmd : CMD_NONE;
  assign add_out   = bus_valid ? bus_addr : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (req_valid) nxt = (n == N_RESET) ? S_CLEAR : S_LOOKUP;
      S_CLEAR:  if (&set_cnt) nxt = S_IDLE;
      S_LOOKUP: begin
        if (is_access(req_n)) begin
          if (tag_hit)        nxt = S_IDLE;
          else if (vic_dirty) nxt = S_EVICT;
          else                nxt = S_FILL;
        end else if ((req_n == N_INVAL) && tag_hit && hit_dirty) begin
          nxt = S_EVICT;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_EVICT:  if (bus_ready) nxt = (req_n == N_INVAL) ? S_IDLE : S_FILL;
      S_FILL:   if (bus_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Control: clear sweep position and the one-cycle response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      set_cnt    <= '0;
      clr_resp   <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      case (state)
        S_IDLE: if (req_valid && (n == N_RESET)) begin
          set_cnt  <= '0;
          clr_resp <= 1'b1;
        end
        S_CLEAR: begin
          set_cnt <= set_cnt + SET_BITS'(1);
          if (&set_cnt) begin
            clr_resp   <= 1'b0;
            resp_valid <= clr_resp;
          end
        end
        S_LOOKUP: if (nxt == S_IDLE) begin
          resp_valid <= 1'b1;
          resp_hit   <= tag_hit && (is_access(req_n) || (req_n == N_INVAL));
        end
        S_EVICT: if (bus_ready && (req_n == N_INVAL)) begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b1;
        end
        S_FILL: if (bus_ready) resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // Request capture and bus request payload.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && req_valid) begin
      req_n    <= n;
      req_line <= add_in[ADDR_W-1:OFFSET_BITS];
    end
    if (state == S_LOOKUP) begin
      vic_way <= evict_way;
      if (nxt == S_EVICT) begin
        bus_addr <= {tag_arr[req_idx][evict_way], req_idx};
        bus_cmd  <= CMD_WB;
      end else begin
        bus_addr <= req_line;
        bus_cmd  <= fill_cmd(req_n);
      end
    end
    if ((state == S_EVICT) && bus_ready) begin
      bus_addr <= req_line;
      bus_cmd  <= fill_cmd(req_n);
    end
  end

  // Tag/valid/dirty/age arrays; the clear sweep initialises them after reset.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      valid_arr[set_cnt] <= '0;
      dirty_arr[set_cnt] <= '0;
      age_arr[set_cnt]   <= ages_init();
    end
    if ((state == S_LOOKUP) && tag_hit && is_access(req_n)) begin
      age_arr[req_idx] <= ages_next;
      if (req_n == N_WRITE) dirty_arr[req_idx][hit_way] <= 1'b1;
    end
    if ((state == S_LOOKUP) && tag_hit && (req_n == N_INVAL) && !hit_dirty)
      valid_arr[req_idx][hit_way] <= 1'b0;
    if ((state == S_EVICT) && bus_ready && (req_n == N_INVAL)) begin
      valid_arr[req_idx][vic_way] <= 1'b0;
      dirty_arr[req_idx][vic_way] <= 1'b0;
    end
    if ((state == S_FILL) && bus_ready) begin
      tag_arr[req_idx][vic_way]   <= req_tag;
      valid_arr[req_idx][vic_way] <= 1'b1;
      dirty_arr[req_idx][vic_way] <= (req_n == N_WRITE);
      age_arr[req_idx]            <= ages_next;
    end
  end

`ifdef DC_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || ((state == S_IDLE) && req_valid && (n == N_RESET))) begin
      hit    <= '0;
      miss   <= '0;
      reads  <= '0;
      writes <= '0;
    end else if (state == S_LOOKUP) begin
      if (req_n == N_READ)  reads  <= sat_inc(reads);
      if (req_n == N_WRITE) writes <= sat_inc(writes);
      if (is_access(req_n)) begin
        if (tag_hit) hit  <= sat_inc(hit);
        else         miss <= sat_inc(miss);
      end
    end
  end
`else
  assign hit    = '0;
  assign miss   = '0;
  assign reads  = '0;
  assign writes = '0;
`endif

endmodule

// File: tb/tb_dc_cache_wb.sv
// Bench for dc_cache_wb (SET_BITS=2, WAYS=4): directed table, hand sequences, random vs model.
`timescale 1ns/1ps
module tb_dc_cache_wb;
  localparam int WAYS = 4, SET_BITS = 2, OFFSET_BITS = 6, ADDR_W = 32, CNT_W = 32;
  localparam int SETS = 4, LINE_W = 26;

  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, bus_ready = 1'b0;
  logic [3:0] n = '0;
  logic [ADDR_W-1:0] add_in = '0;
  logic req_ready, resp_valid, resp_hit, bus_valid;
  logic [LINE_W-1:0] add_out;
  logic [1:0] cmd_out;
  logic [CNT_W-1:0] hit, miss, reads, writes;

  dc_cache_wb #(.WAYS(WAYS), .SET_BITS(SET_BITS), .OFFSET_BITS(OFFSET_BITS),
                .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .n(n), .add_in(add_in), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .add_out(add_out), .cmd_out(cmd_out),
    .hit(hit), .miss(miss), .reads(reads), .writes(writes));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: per-line valid/dirty/tag plus last-use timestamps for LRU.
  logic   m_v [SETS][WAYS];
  logic   m_d [SETS][WAYS];
  int     m_tag [SETS][WAYS];
  longint m_stamp [SETS][WAYS];
  longint m_tick, m_hits, m_miss, m_reads, m_writes;

  logic        e_hit;
  int          e_ntx;
  logic [1:0]  e_cmd [2];
  logic [25:0] e_addr [2];

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 1'b0; m_d[s][w] = 1'b0; m_tag[s][w] = 0;
        m_stamp[s][w] = -longint'(w);
      end
    m_tick = 1; m_hits = 0; m_miss = 0; m_reads = 0; m_writes = 0;
  endfunction

  function automatic logic [63:0] stat(input longint v);
`ifdef DC_STATS_EN
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  function automatic void m_step(input logic [3:0] c, input logic [31:0] a);
    int s, t, hw, vw;
    longint best;
    s = int'(a[7:6]);
    t = int'(a[31:8]);
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_tag[s][w] == t) hw = w;
    e_hit = 1'b0;
    e_ntx = 0;
    if (c == 4'd0 || c == 4'd1) begin
      if (c == 4'd0) m_reads++; else m_writes++;
      if (hw >= 0) begin
        m_hits++;
        e_hit = 1'b1;
        m_stamp[s][hw] = m_tick++;
        if (c == 4'd1) m_d[s][hw] = 1'b1;
      end else begin
        m_miss++;
        vw = -1;
        for (int w = WAYS-1; w >= 0; w--) if (!m_v[s][w]) vw = w;
        if (vw < 0) begin
          best = 64'h7FFF_FFFF_FFFF_FFFF;
          for (int w = 0; w < WAYS; w++)
            if (m_stamp[s][w] < best) begin best = m_stamp[s][w]; vw = w; end
        end
        if (m_v[s][vw] && m_d[s][vw]) begin
          e_cmd[0] = 2'b10;
          e_addr[0] = 26'((m_tag[s][vw] << 2) | s);
          e_ntx = 1;
        end
        e_cmd[e_ntx] = (c == 4'd1) ? 2'b11 : 2'b01;
        e_addr[e_ntx] = a[31:6];
        e_ntx++;
        m_tag[s][vw] = t; m_v[s][vw] = 1'b1; m_d[s][vw] = (c == 4'd1);
        m_stamp[s][vw] = m_tick++;
      end
    end else if (c == 4'd3) begin
      if (hw >= 0) begin
        e_hit = 1'b1;
        if (m_d[s][hw]) begin e_cmd[0] = 2'b10; e_addr[0] = a[31:6]; e_ntx = 1; end
        m_v[s][hw] = 1'b0; m_d[s][hw] = 1'b0;
      end
    end else if (c == 4'd8) begin
      m_reset();
    end
  endfunction

  task automatic check_counters(input string tag);
    check({tag, " hit_cnt"},  64'(hit),    stat(m_hits));
    check({tag, " miss_cnt"}, 64'(miss),   stat(m_miss));
    check({tag, " reads"},    64'(reads),  stat(m_reads));
    check({tag, " writes"},   64'(writes), stat(m_writes));
  endtask

  // Issue one command and follow it to resp_valid, serving bus requests.
  task automatic run_cmd(input string tag, input logic [3:0] c, input logic [31:0] a, input int hold);
    int k, held, cyc;
    bit done;
    k = 0; held = 0; done = 0;
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; n = c; add_in = a;
    @(negedge clk);
    req_valid = 1'b0; n = 4'($urandom); add_in = $urandom;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      if (resp_valid) begin
        check({tag, " resp_hit"}, 64'(resp_hit), 64'(e_hit));
        check({tag, " bus_count"}, 64'(k), 64'(e_ntx));
        if (e_ntx == 0 && c != 4'd8) check({tag, " latency"}, 64'(cyc), 64'd1);
        check_counters(tag);
        done = 1;
      end else begin
        if (bus_valid) begin
          check({tag, " req_ready_busy"}, 64'(req_ready), 64'd0);
          if (k < e_ntx) begin
            check({tag, " cmd_out"}, 64'(cmd_out), 64'(e_cmd[k]));
            check({tag, " add_out"}, 64'(add_out), 64'(e_addr[k]));
          end else begin
            check({tag, " extra_bus_req"}, 64'(k), 64'(e_ntx));
          end
          if (held < hold) begin bus_ready = 1'b0; held++; end
          else bus_ready = ($urandom_range(0, 3) != 0);
          if (bus_ready) k++;
        end else begin
          bus_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end
    if (!done) check({tag, " timeout"}, 64'd0, 64'd1);
    bus_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic        h;
    int          ntx;
    logic [1:0]  c0;
    logic [25:0] a0;
    logic [1:0]  c1;
    logic [25:0] a1;
    int          hold;
  } vec_t;

  vec_t vt [17];

  initial begin
    logic [3:0] rc;
    logic [31:0] ra;
    int r;

    vt[0]  = '{4'd0, 32'h040, 1'b0, 1, 2'b01, 26'h1,  2'b00, 26'h0,  0};
    vt[1]  = '{4'd0, 32'h040, 1'b1, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};
    vt[2]  = '{4'd1, 32'h000, 1'b0, 1, 2'b11, 26'h0,  2'b00, 26'h0,  0};
    vt[3]  = '{4'd1, 32'h100, 1'b0, 1, 2'b11, 26'h4,  2'b00, 26'h0,  0};
    vt[4]  = '{4'd1, 32'h200, 1'b0, 1, 2'b11, 26'h8,  2'b00, 26'h0,  0};
    vt[5]  = '{4'd1, 32'h300, 1'b0, 1, 2'b11, 26'hC,  2'b00, 26'h0,  0};
    vt[6]  = '{4'd1, 32'h400, 1'b0, 2, 2'b10, 26'h0,  2'b11, 26'h10, 0};
    vt[7]  = '{4'd1, 32'h080, 1'b0, 1, 2'b11, 26'h2,  2'b00, 26'h0,  7};
    vt[8]  = '{4'd3, 32'h080, 1'b1, 1, 2'b10, 26'h2,  2'b00, 26'h0,  0};
    vt[9]  = '{4'd0, 32'h080, 1'b0, 1, 2'b01, 26'h2,  2'b00, 26'h0,  0};
    vt[10] = '{4'd9, 32'h400, 1'b0, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};
    vt[11] = '{4'd5, 32'h100, 1'b0, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};
    vt[12] = '{4'd3, 32'h040, 1'b1, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};
    vt[13] = '{4'd3, 32'h040, 1'b0, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};
    vt[14] = '{4'd1, 32'h100, 1'b1, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};
    vt[15] = '{4'd1, 32'h040, 1'b0, 1, 2'b11, 26'h1,  2'b00, 26'h0,  0};
    vt[16] = '{4'd8, 32'h000, 1'b0, 0, 2'b00, 26'h0,  2'b00, 26'h0,  0};

    // Power-on reset: one low cycle, then four clear cycles.
    m_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst cmd_out", 64'(cmd_out), 64'd0);
    check_counters("rst");
    for (int i = 0; i < 4; i++) begin
      check("rst req_ready_low", 64'(req_ready), 64'd0);
      check("rst bus_valid", 64'(bus_valid), 64'd0);
      @(negedge clk);
    end
    check("rst req_ready_high", 64'(req_ready), 64'd1);

    for (int i = 0; i < 17; i++) begin
      m_step(vt[i].c, vt[i].a);
      e_hit = vt[i].h; e_ntx = vt[i].ntx;
      e_cmd[0] = vt[i].c0; e_addr[0] = vt[i].a0;
      e_cmd[1] = vt[i].c1; e_addr[1] = vt[i].a1;
      run_cmd($sformatf("vec%0d", i), vt[i].c, vt[i].a, vt[i].hold);
    end

    // Fill set 3 with dirty lines, then reset while a writeback is pending.
    for (int i = 0; i < 4; i++) begin
      ra = 32'h0C0 | (32'(i) << 8);
      m_step(4'd1, ra);
      run_cmd($sformatf("fill3_%0d", i), 4'd1, ra, 0);
    end
    @(negedge clk);
    req_valid = 1'b1; n = 4'd1; add_in = 32'h4C0;
    @(negedge clk);
    req_valid = 1'b0;
    bus_ready = 1'b0;
    for (int i = 0; i < 10 && !bus_valid; i++) @(negedge clk);
    check("evict cmd_out", 64'(cmd_out), 64'd2);
    check("evict add_out", 64'(add_out), 64'h3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    check("abort bus_valid", 64'(bus_valid), 64'd0);
    check("abort cmd_out", 64'(cmd_out), 64'd0);
    check("abort resp_valid", 64'(resp_valid), 64'd0);
    check_counters("abort");
    for (int i = 0; i < 4; i++) begin
      check("abort req_ready_low", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    check("abort req_ready_high", 64'(req_ready), 64'd1);
    m_step(4'd0, 32'h0C0);
    run_cmd("after_abort", 4'd0, 32'h0C0, 0);

    // Random traffic on a small tag range to force conflicts and evictions.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 39);
      if (r < 16)      rc = 4'd0;
      else if (r < 30) rc = 4'd1;
      else if (r < 36) rc = 4'd3;
      else if (r < 38) rc = 4'd9;
      else if (r < 39) rc = 4'($urandom_range(10, 15));
      else             rc = 4'd8;
      ra = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 6)
           | 32'($urandom_range(0, 63));
      m_step(rc, ra);
      run_cmd($sformatf("rnd%0d", i), rc, ra, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
